// File: rtl/flash_pkg.sv
// Shared definitions for the 8-bit NOR flash bus: command bytes, status
// register layout, identification bytes and responder state encodings.
package flash_pkg;

    // Command bytes carried on the data bus of a write cycle
    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
    localparam logic [7:0] CMD_READ_SR    = 8'h70;
    localparam logic [7:0] CMD_READ_ID    = 8'h90;
    localparam logic [7:0] CMD_CLR_SR     = 8'h50;
    localparam logic [7:0] CMD_PROG       = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT   = 8'h10;
    localparam logic [7:0] CMD_ERASE      = 8'h20;
    localparam logic [7:0] CMD_CONFIRM    = 8'hD0;

    // Status register bit positions
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_PROTECT   = 1;

    // Status register value after reset or abort, and the bits that exist
    localparam logic [7:0] SR_RESET      = 8'h80;
    localparam logic [7:0] SR_VALID_MASK = 8'hB2;

    // Manufacturer byte returned by the ID read at address 0
    localparam logic [7:0] MANUF_ID = 8'h89;

    // Responder states (fixed encodings kept stable for older users)
    localparam logic [2:0] ST_INIT        = 3'd0;
    localparam logic [2:0] ST_READY       = 3'd1;
    localparam logic [2:0] ST_PROG_SETUP  = 3'd2;
    localparam logic [2:0] ST_PROG_BUSY   = 3'd3;
    localparam logic [2:0] ST_ERASE_SETUP = 3'd4;
    localparam logic [2:0] ST_ERASE_BUSY  = 3'd5;

    // Read modes
    localparam logic [1:0] MODE_ARRAY  = 2'd0;
    localparam logic [1:0] MODE_STATUS = 2'd1;
    localparam logic [1:0] MODE_ID     = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits 6, 3, 2 and 0 of the status register never read as 1
    function automatic logic [7:0] sr_visible(input logic [7:0] sr);
        return sr & SR_VALID_MASK;
    endfunction

endpackage

// File: rtl/flash_array.sv
// 256x8 single-port storage with a registered read port. A write and a
// read of the same address in one cycle return the old contents.
module flash_array (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] mem_r [0:255];

    // Single port: optional write, and a read of the same address every cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/flash_responder.sv
// Device end of the parallel NOR flash bus: command decoder, busy timing,
// status register and read-data path around a 256-byte array.
module flash_responder
    import flash_pkg::*;
#(
    parameter int         PROG_CYCLES = 16,
    parameter int         ERASE_PAD   = 32,
    parameter int         BLOCK_AW    = 4,
    parameter logic [7:0] DEVICE_ID   = 8'h16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       NF_CE,
    input  logic       NF_BYTE,
    input  logic       NF_OE,
    input  logic       NF_RP,
    input  logic       NF_WE,
    input  logic       NF_WP,
    output logic       NF_STS,
    input  logic [7:0] NF_A,
    inout  wire  [7:0] NF_D
);

    localparam int SWEEP_CNT   = 1 << BLOCK_AW;
    localparam int ERASE_TOTAL = SWEEP_CNT + ERASE_PAD;
    localparam int CNT_W       = $clog2(max_int(PROG_CYCLES, ERASE_TOTAL)) + 1;
    localparam int BLK_W       = 8 - BLOCK_AW;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_TOTAL - 1);
    localparam logic [CNT_W-1:0] SWEEP_LEN  = CNT_W'(SWEEP_CNT);

    logic [2:0]       state_r;
    logic [1:0]       mode_r;
    logic [7:0]       sr_r;
    logic             sts_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       init_addr_r;
    logic             we_prev_r;
    logic [7:0]       tgt_addr_r;
    logic [7:0]       tgt_data_r;
    logic             op_ok_r;
    logic             rd_sel_array_r;
    logic [7:0]       rd_aux_r;

    logic             write_evt_s;
    logic [7:0]       din_s;
    logic             busy_s;
    logic             ram_we_s;
    logic [7:0]       ram_addr_s;
    logic [7:0]       ram_din_s;
    logic [7:0]       ram_dout_s;
    logic [7:0]       id_byte_s;
    logic [7:0]       aux_next_s;
    logic             sel_array_next_s;
    logic [7:0]       rd_data_s;
    logic             drive_s;
    logic             byte_unused_s;

    // The part is x8 only, so the byte-mode pin has no effect
    assign byte_unused_s = NF_BYTE;

    assign din_s       = NF_D;
    assign write_evt_s = ~we_prev_r & NF_WE & ~NF_CE;
    assign busy_s      = (state_r == ST_INIT) || (state_r == ST_PROG_BUSY) ||
                         (state_r == ST_ERASE_BUSY);

    flash_array u_array (
        .clk  (CLK_50MHZ),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (ram_din_s),
        .dout (ram_dout_s)
    );

    // Array port owner: init sweep, program read-modify-write, erase sweep, or bus reads
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = NF_A;
        ram_din_s  = 8'hFF;
        case (state_r)
            ST_INIT: begin
                ram_we_s   = 1'b1;
                ram_addr_s = init_addr_r;
            end
            ST_PROG_BUSY: begin
                // first busy cycle reads the old byte, the second writes the ANDed value
                ram_addr_s = tgt_addr_r;
                ram_din_s  = ram_dout_s & tgt_data_r;
                if (cnt_r == CNT_ONE) begin
                    ram_we_s = op_ok_r;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            ST_ERASE_BUSY: begin
                ram_addr_s = {tgt_addr_r[7:BLOCK_AW], cnt_r[BLOCK_AW-1:0]};
                if (cnt_r < SWEEP_LEN) begin
                    ram_we_s = op_ok_r;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            default: begin
                ram_we_s   = 1'b0;
                ram_addr_s = NF_A;
            end
        endcase
    end

    // Identification bytes by address
    always_comb begin
        id_byte_s = 8'h00;
        if (NF_A == 8'h00) begin
            id_byte_s = MANUF_ID;
        end else if (NF_A == 8'h01) begin
            id_byte_s = DEVICE_ID;
        end else begin
            id_byte_s = 8'h00;
        end
    end

    // Choose what the next read cycle presents; busy phases always show status
    always_comb begin
        aux_next_s       = 8'h00;
        sel_array_next_s = 1'b0;
        if (busy_s) begin
            aux_next_s = sr_visible(sr_r);
        end else begin
            case (mode_r)
                MODE_ARRAY:  sel_array_next_s = 1'b1;
                MODE_STATUS: aux_next_s = sr_visible(sr_r);
                MODE_ID:     aux_next_s = id_byte_s;
                default:     aux_next_s = 8'h00;
            endcase
        end
    end

    // Read-data registers, refreshed every cycle from the current address and mode
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            rd_sel_array_r <= 1'b0;
            rd_aux_r       <= 8'h00;
        end else begin
            rd_sel_array_r <= sel_array_next_s;
            rd_aux_r       <= aux_next_s;
        end
    end

    assign rd_data_s = rd_sel_array_r ? ram_dout_s : rd_aux_r;
    assign drive_s   = ~NF_CE & ~NF_OE & NF_WE;
    assign NF_D      = drive_s ? rd_data_s : 8'hzz;
    assign NF_STS    = sts_r;

    // Command decoder, busy timing and status register
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state_r     <= ST_INIT;
            mode_r      <= MODE_ARRAY;
            sr_r        <= SR_RESET;
            sts_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            init_addr_r <= 8'h00;
            we_prev_r   <= 1'b1;
            tgt_addr_r  <= 8'h00;
            tgt_data_r  <= 8'h00;
            op_ok_r     <= 1'b0;
        end else begin
            we_prev_r <= NF_WE;
            if (!NF_RP && (state_r != ST_INIT)) begin
                // reset/powerdown abandons the operation but keeps the array
                state_r <= ST_READY;
                mode_r  <= MODE_ARRAY;
                sr_r    <= SR_RESET;
                sts_r   <= 1'b1;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_INIT: begin
                        init_addr_r <= init_addr_r + 8'd1;
                        if (init_addr_r == 8'hFF) begin
                            state_r <= ST_READY;
                            sts_r   <= 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (write_evt_s) begin
                            case (din_s)
                                CMD_READ_ARRAY: mode_r <= MODE_ARRAY;
                                CMD_READ_SR:    mode_r <= MODE_STATUS;
                                CMD_READ_ID:    mode_r <= MODE_ID;
                                CMD_CLR_SR:     sr_r[5:1] <= 5'b00000;
                                CMD_PROG,
                                CMD_PROG_ALT:   state_r <= ST_PROG_SETUP;
                                CMD_ERASE:      state_r <= ST_ERASE_SETUP;
                                default:        state_r <= ST_READY;
                            endcase
                        end
                    end
                    ST_PROG_SETUP: begin
                        if (write_evt_s) begin
                            tgt_addr_r       <= NF_A;
                            tgt_data_r       <= din_s;
                            op_ok_r          <= NF_WP;
                            sr_r[SR_READY]   <= 1'b0;
                            if (!NF_WP) begin
                                sr_r[SR_PROG_ERR] <= 1'b1;
                                sr_r[SR_PROTECT]  <= 1'b1;
                            end
                            mode_r  <= MODE_STATUS;
                            state_r <= ST_PROG_BUSY;
                            sts_r   <= 1'b0;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    ST_ERASE_SETUP: begin
                        if (write_evt_s) begin
                            mode_r <= MODE_STATUS;
                            if (din_s != CMD_CONFIRM) begin
                                // bad confirm: flag a command sequence error, no busy phase
                                sr_r[SR_ERASE_ERR] <= 1'b1;
                                sr_r[SR_PROG_ERR]  <= 1'b1;
                                state_r            <= ST_READY;
                            end else begin
                                tgt_addr_r     <= NF_A;
                                op_ok_r        <= NF_WP;
                                sr_r[SR_READY] <= 1'b0;
                                if (!NF_WP) begin
                                    sr_r[SR_ERASE_ERR] <= 1'b1;
                                    sr_r[SR_PROTECT]   <= 1'b1;
                                end
                                state_r <= ST_ERASE_BUSY;
                                sts_r   <= 1'b0;
                                cnt_r   <= CNT_ZERO;
                            end
                        end
                    end
                    ST_PROG_BUSY: begin
                        if (cnt_r == PROG_LAST) begin
                            sr_r[SR_READY] <= 1'b1;
                            sts_r          <= 1'b1;
                            state_r        <= ST_READY;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_ERASE_BUSY: begin
                        if (cnt_r == ERASE_LAST) begin
                            sr_r[SR_READY] <= 1'b1;
                            sts_r          <= 1'b1;
                            state_r        <= ST_READY;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_READY;
                        sts_r   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: init sweep, program, erase, protect,
// ID/status reads, abort and writes during busy.
module tb_flash_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       nf_ce;
    logic       nf_byte;
    logic       nf_oe;
    logic       nf_rp;
    logic       nf_we;
    logic       nf_wp;
    logic       nf_sts;
    logic [7:0] nf_a;
    logic [7:0] drv_d;
    logic       drv_en;
    wire  [7:0] nf_d;

    int n_cmp = 0;
    int n_err = 0;

    assign nf_d = drv_en ? drv_d : 8'hzz;

    flash_responder dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .NF_CE     (nf_ce),
        .NF_BYTE   (nf_byte),
        .NF_OE     (nf_oe),
        .NF_RP     (nf_rp),
        .NF_WE     (nf_we),
        .NF_WP     (nf_wp),
        .NF_STS    (nf_sts),
        .NF_A      (nf_a),
        .NF_D      (nf_d)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Two-cycle write: WE low for one cycle, then high with CE still low
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        nf_oe  = 1'b1;
        nf_ce  = 1'b0;
        nf_a   = a;
        drv_d  = d;
        drv_en = 1'b1;
        nf_we  = 1'b0;
        @(negedge clk);
        nf_we  = 1'b1;
        @(negedge clk);
        nf_ce  = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        nf_a  = a;
        nf_ce = 1'b0;
        nf_oe = 1'b0;
        @(negedge clk);
        d     = nf_d;
        nf_oe = 1'b1;
        nf_ce = 1'b1;
    endtask

    task automatic expect_read(input string tag, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] v;
        bus_read(a, v);
        check_val(tag, {24'h0, v}, {24'h0, e});
    endtask

    // Counts consecutive negedge samples with NF_STS low, bounded
    task automatic wait_ready(output int n);
        n = 0;
        while (nf_sts == 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; nf_ce = 1'b1; nf_byte = 1'b1; nf_oe = 1'b1; nf_rp = 1'b1;
        nf_we = 1'b1; nf_wp = 1'b1; nf_a = 8'h00; drv_d = 8'h00; drv_en = 1'b0;

        // Reset and init sweep
        repeat (2) @(negedge clk);
        check_val("rst_sts", {31'h0, nf_sts}, 32'h0);
        rst = 1'b1;
        wait_ready(n);
        check_val("init_busy", n, 32'd256);
        expect_read("init_35", 8'h35, 8'hFF);
        expect_read("init_ff", 8'hFF, 8'hFF);

        // Program clears bits only
        bus_write(8'h00, 8'h40);
        bus_write(8'h35, 8'hC9);
        wait_ready(n);
        check_val("prog_busy", n, 32'd16);
        expect_read("prog_sr", 8'h00, 8'h80);
        bus_write(8'h00, 8'hFF);
        expect_read("prog_35", 8'h35, 8'hC9);
        bus_write(8'h00, 8'h10);
        bus_write(8'h35, 8'h3F);
        wait_ready(n);
        bus_write(8'h00, 8'hFF);
        expect_read("prog_and", 8'h35, 8'h09);
        bus_write(8'h00, 8'h40);
        bus_write(8'h2F, 8'h5A);
        wait_ready(n);

        // Block erase of 0x30..0x3F
        bus_write(8'h00, 8'h20);
        bus_write(8'h35, 8'hD0);
        wait_ready(n);
        check_val("erase_busy", n, 32'd48);
        bus_write(8'h00, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            expect_read("erase_blk", 8'h30 + 8'(i), 8'hFF);
        end
        expect_read("erase_keep", 8'h2F, 8'h5A);

        // Bad confirm: error flags, no busy phase
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'h55);
        check_val("badconf_sts", {31'h0, nf_sts}, 32'h1);
        expect_read("badconf_sr", 8'h00, 8'hB0);
        bus_write(8'h00, 8'h50);

        // Write-protected program
        nf_wp = 1'b0;
        bus_write(8'h00, 8'h40);
        bus_write(8'h10, 8'h00);
        wait_ready(n);
        check_val("wp_busy", n, 32'd16);
        nf_wp = 1'b1;
        expect_read("wp_sr", 8'h00, 8'h92);
        bus_write(8'h00, 8'h50);
        expect_read("clr_sr", 8'h00, 8'h80);
        bus_write(8'h00, 8'hFF);
        expect_read("wp_mem", 8'h10, 8'hFF);

        // ID and status modes
        bus_write(8'h00, 8'h90);
        expect_read("id_0", 8'h00, 8'h89);
        expect_read("id_1", 8'h01, 8'h16);
        expect_read("id_2", 8'h02, 8'h00);
        bus_write(8'h00, 8'h70);
        expect_read("sr_mode", 8'h77, 8'h80);

        // Abort an erase eight cycles in
        bus_write(8'h00, 8'h20);
        bus_write(8'h45, 8'hD0);
        repeat (8) @(negedge clk);
        check_val("abort_pre", {31'h0, nf_sts}, 32'h0);
        nf_rp = 1'b0;
        @(negedge clk);
        nf_rp = 1'b1;
        check_val("abort_sts", {31'h0, nf_sts}, 32'h1);
        expect_read("abort_array", 8'h2F, 8'h5A);
        bus_write(8'h00, 8'h70);
        expect_read("abort_sr", 8'h00, 8'h80);

        // Writes during a program busy phase are ignored
        bus_write(8'h00, 8'h40);
        bus_write(8'h60, 8'hA5);
        expect_read("busy_sr", 8'h60, 8'h00);
        bus_write(8'h60, 8'h00);
        wait_ready(n);
        check_val("busy_end", {31'h0, nf_sts}, 32'h1);
        bus_write(8'h00, 8'hFF);
        expect_read("busy_write", 8'h60, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
